// File: rtl/mc_maindec.sv
// mc_maindec: multicycle main control FSM for the MIPS datapath.
// Each instruction is stepped through fetch/decode/execute/memory/writeback
// states that share one ALU and one memory port. mem_ready inserts wait
// states in FETCH, MEMRD and MEMWR.
// Optional feature macro: MC_BNE_EN adds the BNEEX state for opcode 000101.
// Without it, 000101 is an unknown opcode and the bne output stays 0.
// ILLEGAL_TRAP selects whether unknown opcodes halt (1) or act as a NOP (0).
module mc_maindec #(
  parameter int STATE_W      = 4,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               branch,
  output logic               bne,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               memtoreg,
  output logic               regdst,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [1:0]         aluop,
  output logic [STATE_W-1:0] state,
  output logic               illegal
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = STATE_W'(0),
    S_DECODE  = STATE_W'(1),
    S_MEMADR  = STATE_W'(2),
    S_MEMRD   = STATE_W'(3),
    S_MEMWB   = STATE_W'(4),
    S_MEMWR   = STATE_W'(5),
    S_RTYPEEX = STATE_W'(6),
    S_ALUWB   = STATE_W'(7),
    S_BEQEX   = STATE_W'(8),
    S_ADDIEX  = STATE_W'(9),
    S_ADDIWB  = STATE_W'(10),
    S_JEX     = STATE_W'(11),
    S_BNEEX   = STATE_W'(12),
    S_HALT    = STATE_W'(15)
  } state_t;

  state_t r_state;
  state_t w_next;
  // op is only valid during DECODE, so lw/sw is remembered for MEMADR.
  logic   r_is_sw;

  // State register with synchronous reset to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Capture whether the memory instruction being decoded is a store.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_is_sw <= 1'b0;
    end else if (r_state == S_DECODE) begin
      r_is_sw <= (op == 6'b101011);
    end
  end

  // Next-state logic; unused encodings fall back to FETCH.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:   w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          6'b100011, 6'b101011: w_next = S_MEMADR;
          6'b000000:            w_next = S_RTYPEEX;
          6'b000100:            w_next = S_BEQEX;
          6'b001000:            w_next = S_ADDIEX;
          6'b000010:            w_next = S_JEX;
`ifdef MC_BNE_EN
          6'b000101:            w_next = S_BNEEX;
`endif
          default:              w_next = ILLEGAL_TRAP ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR:  w_next = r_is_sw ? S_MEMWR : S_MEMRD;
      S_MEMRD:   w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   w_next = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: w_next = S_ALUWB;
      S_ADDIEX:  w_next = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BEQEX, S_JEX: w_next = S_FETCH;
`ifdef MC_BNE_EN
      S_BNEEX:   w_next = S_FETCH;
`endif
      S_HALT:    w_next = S_HALT;
      default:   w_next = S_FETCH;
    endcase
  end

  // Moore outputs decoded from the current state; everything defaults to 0.
  always_comb begin
    pcwrite  = 1'b0;
    branch   = 1'b0;
    bne      = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = 2'b00;
    illegal  = 1'b0;
    case (r_state)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      S_DECODE:  alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD:   iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB:  regwrite = 1'b1;
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
`ifdef MC_BNE_EN
      S_BNEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        bne     = 1'b1;
      end
`endif
      S_HALT:    illegal = 1'b1;
      default: begin
        illegal = 1'b0;
      end
    endcase
  end

  assign state = r_state;

endmodule

// File: tb/tb_mc_maindec.sv
// tb_mc_maindec: directed bench for mc_maindec. Two instances share the
// stimulus: u_trap (ILLEGAL_TRAP=1) and u_nop (ILLEGAL_TRAP=0). Each cycle
// the driver pushes the expected state of both instances (derived from the
// instruction's cycle recipe) and the expected outputs follow from a state
// table; a single compare process checks them on the falling edge.
module tb_mc_maindec;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       mem_ready;
  logic [5:0] op;

  logic       a_pcwrite, a_branch, a_bne, a_iord, a_memwrite, a_irwrite;
  logic       a_memtoreg, a_regdst, a_regwrite, a_alusrca, a_illegal;
  logic [1:0] a_alusrcb, a_pcsrc, a_aluop;
  logic [3:0] a_state;
  logic       b_pcwrite, b_branch, b_bne, b_iord, b_memwrite, b_irwrite;
  logic       b_memtoreg, b_regdst, b_regwrite, b_alusrca, b_illegal;
  logic [1:0] b_alusrcb, b_pcsrc, b_aluop;
  logic [3:0] b_state;

  mc_maindec #(.STATE_W(4), .ILLEGAL_TRAP(1'b1)) u_trap (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .pcwrite(a_pcwrite), .branch(a_branch), .bne(a_bne), .iord(a_iord),
    .memwrite(a_memwrite), .irwrite(a_irwrite), .memtoreg(a_memtoreg),
    .regdst(a_regdst), .regwrite(a_regwrite), .alusrca(a_alusrca),
    .alusrcb(a_alusrcb), .pcsrc(a_pcsrc), .aluop(a_aluop),
    .state(a_state), .illegal(a_illegal)
  );

  mc_maindec #(.STATE_W(4), .ILLEGAL_TRAP(1'b0)) u_nop (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .pcwrite(b_pcwrite), .branch(b_branch), .bne(b_bne), .iord(b_iord),
    .memwrite(b_memwrite), .irwrite(b_irwrite), .memtoreg(b_memtoreg),
    .regdst(b_regdst), .regwrite(b_regwrite), .alusrca(b_alusrca),
    .alusrcb(b_alusrcb), .pcsrc(b_pcsrc), .aluop(b_aluop),
    .state(b_state), .illegal(b_illegal)
  );

  logic [16:0] a_outs, b_outs;
  assign a_outs = {a_pcwrite, a_branch, a_bne, a_iord, a_memwrite, a_irwrite,
                   a_memtoreg, a_regdst, a_regwrite, a_alusrca, a_alusrcb,
                   a_pcsrc, a_aluop, a_illegal};
  assign b_outs = {b_pcwrite, b_branch, b_bne, b_iord, b_memwrite, b_irwrite,
                   b_memtoreg, b_regdst, b_regwrite, b_alusrca, b_alusrcb,
                   b_pcsrc, b_aluop, b_illegal};

  // ---------------- scoreboard state ----------------
  // Entry: {trap state[3:0], nop state[3:0], mem_ready}
  logic [8:0] exp_q[$];
  int n_checks  = 0;
  int n_fail    = 0;
  int trace_len = 0;
  int mw_cnt    = 0;
  int ir_cnt    = 0;
  int len;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Spec output table, indexed by state encoding.
  function automatic logic [16:0] exp_outs(input logic [3:0] s, input logic mr);
    logic pcw, br, bn, io, mw, irw, m2r, rd, rw, sa, ill;
    logic [1:0] sb, ps, ao;
    {pcw, br, bn, io, mw, irw, m2r, rd, rw, sa, ill} = '0;
    sb = 2'b00; ps = 2'b00; ao = 2'b00;
    case (s)
      4'd0:  begin sb = 2'b01; irw = mr; pcw = mr; end
      4'd1:  sb = 2'b11;
      4'd2:  begin sa = 1'b1; sb = 2'b10; end
      4'd3:  io = 1'b1;
      4'd4:  begin m2r = 1'b1; rw = 1'b1; end
      4'd5:  begin io = 1'b1; mw = 1'b1; end
      4'd6:  begin sa = 1'b1; ao = 2'b10; end
      4'd7:  begin rd = 1'b1; rw = 1'b1; end
      4'd8:  begin sa = 1'b1; ao = 2'b01; ps = 2'b01; br = 1'b1; end
      4'd9:  begin sa = 1'b1; sb = 2'b10; end
      4'd10: rw = 1'b1;
      4'd11: begin ps = 2'b10; pcw = 1'b1; end
      4'd12: begin sa = 1'b1; ao = 2'b01; ps = 2'b01; bn = 1'b1; end
      4'd15: ill = 1'b1;
      default: ill = 1'b0;
    endcase
    return {pcw, br, bn, io, mw, irw, m2r, rd, rw, sa, sb, ps, ao, ill};
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [8:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("trap_state", 32'(a_state), 32'(e[8:5]));
      chk("trap_outs",  32'(a_outs),  32'(exp_outs(e[8:5], e[0])));
      chk("nop_state",  32'(b_state), 32'(e[4:1]));
      chk("nop_outs",   32'(b_outs),  32'(exp_outs(e[4:1], e[0])));
      if (a_memwrite) mw_cnt++;
      if (a_irwrite)  ir_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [5:0] junk_op();
    return 6'($urandom_range(63, 0));
  endfunction

  // One clock cycle: drive inputs and record the state both DUTs must be in.
  task automatic step(input logic [5:0] o, input logic mr, input logic rst,
                      input logic [3:0] s, input logic [3:0] sn);
    @(posedge clk);
    #1;
    op        = o;
    mem_ready = mr;
    reset     = rst;
    exp_q.push_back({s, sn, mr});
    trace_len++;
  endtask

  // Legal instruction: wf fetch wait cycles, wm memory wait cycles.
  task automatic run_instr(input logic [5:0] o, input int wf, input int wm, output int n);
    trace_len = 0;
    repeat (wf) step(junk_op(), 1'b0, 1'b0, 4'd0, 4'd0);
    step(junk_op(), 1'b1, 1'b0, 4'd0, 4'd0);
    step(o, 1'b1, 1'b0, 4'd1, 4'd1);
    case (o)
      6'b100011: begin
        step(junk_op(), 1'b1, 1'b0, 4'd2, 4'd2);
        repeat (wm) step(junk_op(), 1'b0, 1'b0, 4'd3, 4'd3);
        step(junk_op(), 1'b1, 1'b0, 4'd3, 4'd3);
        step(junk_op(), 1'b1, 1'b0, 4'd4, 4'd4);
      end
      6'b101011: begin
        step(junk_op(), 1'b1, 1'b0, 4'd2, 4'd2);
        repeat (wm) step(junk_op(), 1'b0, 1'b0, 4'd5, 4'd5);
        step(junk_op(), 1'b1, 1'b0, 4'd5, 4'd5);
      end
      6'b000000: begin
        step(junk_op(), 1'b1, 1'b0, 4'd6, 4'd6);
        step(junk_op(), 1'b1, 1'b0, 4'd7, 4'd7);
      end
      6'b001000: begin
        step(junk_op(), 1'b1, 1'b0, 4'd9, 4'd9);
        step(junk_op(), 1'b1, 1'b0, 4'd10, 4'd10);
      end
      6'b000100: step(junk_op(), 1'b1, 1'b0, 4'd8, 4'd8);
      6'b000010: step(junk_op(), 1'b1, 1'b0, 4'd11, 4'd11);
      default:   step(junk_op(), 1'b1, 1'b0, 4'd12, 4'd12);
    endcase
    n = trace_len;
  endtask

  // Unknown opcode: trap DUT halts, nop DUT loops FETCH/DECODE on the same op.
  task automatic run_illegal(input logic [5:0] o, input int hold);
    step(junk_op(), 1'b1, 1'b0, 4'd0, 4'd0);
    step(o, 1'b1, 1'b0, 4'd1, 4'd1);
    for (int k = 0; k < hold; k++)
      step(o, 1'b1, 1'b0, 4'd15, (k % 2 == 0) ? 4'd0 : 4'd1);
    step(o, 1'b1, 1'b1, 4'd15, (hold % 2 == 0) ? 4'd0 : 4'd1);
  endtask

  // Wait until the compare process has consumed the last pushed cycle.
  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset     = 1'b1;
    mem_ready = 1'b1;
    op        = 6'b000000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state",   32'(a_state),   32'd0);
    chk("reset_alusrcb", 32'(a_alusrcb), 32'd1);
    chk("reset_irwrite", 32'(a_irwrite), 32'd1);
    chk("reset_memwr",   32'(a_memwrite), 32'd0);

    run_instr(6'b100011, 0, 0, len); chk("lw_len", 32'(len), 32'd5);

    settle(); mw_cnt = 0;
    run_instr(6'b101011, 0, 2, len); chk("sw_wait_len", 32'(len), 32'd6);
    settle(); chk("sw_memwrite_cycles", 32'(mw_cnt), 32'd3);

    run_instr(6'b000000, 0, 0, len); chk("rtype_len", 32'(len), 32'd4);
    run_instr(6'b001000, 0, 0, len); chk("addi_len",  32'(len), 32'd4);
    run_instr(6'b000100, 0, 0, len); chk("beq_len",   32'(len), 32'd3);
    run_instr(6'b000010, 0, 0, len); chk("j_len",     32'(len), 32'd3);
    run_instr(6'b101011, 0, 0, len); chk("sw_len",    32'(len), 32'd4);

`ifdef MC_BNE_EN
    run_instr(6'b000101, 0, 0, len); chk("bne_len", 32'(len), 32'd3);
`else
    run_illegal(6'b000101, 4);
`endif

    run_illegal(6'b111111, 20);

    settle(); ir_cnt = 0;
    run_instr(6'b000000, 3, 0, len); chk("fetch_wait_len", 32'(len), 32'd7);
    settle(); chk("fetch_wait_irwrite", 32'(ir_cnt), 32'd1);

    // Reset while stalled in MEMRD.
    step(junk_op(),  1'b1, 1'b0, 4'd0, 4'd0);
    step(6'b100011,  1'b1, 1'b0, 4'd1, 4'd1);
    step(junk_op(),  1'b1, 1'b0, 4'd2, 4'd2);
    step(junk_op(),  1'b0, 1'b0, 4'd3, 4'd3);
    step(junk_op(),  1'b0, 1'b1, 4'd3, 4'd3);

    // Reset while stalled in MEMWR; memwrite must drop in the following FETCH.
    step(junk_op(),  1'b1, 1'b0, 4'd0, 4'd0);
    step(6'b101011,  1'b1, 1'b0, 4'd1, 4'd1);
    step(junk_op(),  1'b1, 1'b0, 4'd2, 4'd2);
    step(junk_op(),  1'b0, 1'b1, 4'd5, 4'd5);
    run_instr(6'b000100, 0, 0, len); chk("beq_after_reset_len", 32'(len), 32'd3);

    run_instr(6'b100011, 1, 2, len); chk("lw_waits_len", 32'(len), 32'd8);
    run_instr(6'b001000, 2, 0, len); chk("addi_wait_len", 32'(len), 32'd6);

    settle();
    @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends with a summary.
  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_maindec.md
# mc_maindec

Multicycle main control FSM for the MIPS datapath; successor of the single-cycle main decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states, sharing one ALU and one memory port. It adds a memory-ready handshake for wait states and a configurable illegal-opcode policy. It sits between the instruction register's opcode field and the multicycle datapath enables and muxes, and feeds `aluop` to the existing ALU decoder.

## Interface
- `STATE_W`, 4: width of state register and `state` debug port; must be ≥4.
- `ILLEGAL_TRAP`, 1: 1 = unknown opcode enters HALT; 0 = unknown opcode returns to FETCH (treated as NOP).

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 6: opcode from the instruction register; sampled only in DECODE.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pcwrite` out 1: PC load enable (unconditional).
- `branch` out 1: beq branch qualifier; the datapath ANDs it with ALU zero.
- `bne` out 1: bne branch qualifier; the datapath ANDs it with !zero.
- `iord` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `memwrite` out 1: memory write strobe.
- `irwrite` out 1: instruction register load.
- `memtoreg` out 1: register write-data select, 1 = data register.
- `regdst` out 1: destination select, 1 = rd, 0 = rt.
- `regwrite` out 1: register file write enable.
- `alusrca` out 1: ALU A select, 0 = PC, 1 = register A.
- `alusrcb` out 2: ALU B select, 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = immediate<<2.
- `pcsrc` out 2: PC source, 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `aluop` out 2: 00 = add, 01 = sub, 10 = funct decode.
- `state` out STATE_W: current state, for debug.
- `illegal` out 1: high while in HALT.

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, ALUWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, BNEEX=12, HALT=15.
- Outputs are combinational from the state. Any output not listed for a state is 0.
  - FETCH: alusrcb=01, aluop=00. `irwrite` = `pcwrite` = `mem_ready`.
  - DECODE: alusrcb=11.
  - MEMADR: alusrca=1, alusrcb=10.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1 (held until `mem_ready`).
  - RTYPEEX: alusrca=1, aluop=10.
  - ALUWB: regdst=1, regwrite=1.
  - BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - ADDIEX: alusrca=1, alusrcb=10.
  - ADDIWB: regwrite=1.
  - JEX: pcsrc=10, pcwrite=1.
  - BNEEX: as BEQEX, but bne=1 and branch=0.
  - HALT: illegal=1.
- Transitions:
  - FETCH→DECODE only when `mem_ready`; otherwise stay in FETCH.
  - DECODE dispatches on `op`: 100011/101011→MEMADR, 000000→RTYPEEX, 000100→BEQEX, 001000→ADDIEX, 000010→JEX, 000101→BNEEX (macro only); any other opcode follows ILLEGAL_TRAP.
  - MEMADR→MEMRD for lw; MEMADR→MEMWR for sw.
  - MEMRD→MEMWB when `mem_ready`; otherwise stay in MEMRD.
  - MEMWR→FETCH when `mem_ready`; otherwise stay in MEMWR.
  - RTYPEEX→ALUWB; ADDIEX→ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BEQEX, BNEEX and JEX→FETCH.
  - HALT→HALT until reset.
- Unused encodings (13, 14 and any code above 15) → FETCH on the next edge. `illegal` stays 0 in these states.

## Timing
- Reset: on the edge with `reset`=1, state←FETCH, regardless of the current state. This includes mid-MEMWR, so `memwrite` drops the following cycle.
- Outputs after reset: all 0 except alusrcb=01. `irwrite`/`pcwrite` follow `mem_ready`.
- Cycle counts with `mem_ready` tied high: lw 5, sw 4, R-type 4, addi 4, beq 3, bne 3, j 3.
- Each low cycle of `mem_ready` in FETCH, MEMRD or MEMWR adds exactly one cycle.
- `op` must be stable during the DECODE cycle. It is ignored in all other states.

## Configuration
- `MC_BNE_EN` defined: opcode 000101 dispatches to BNEEX (one cycle asserting `bne`) and then returns to FETCH.
- `MC_BNE_EN` undefined: BNEEX logic is not compiled. Opcode 000101 is treated as illegal. The `bne` port stays present and is tied to 0.

## Test plan
- Reset, `mem_ready`=1, op=100011 (lw) → states 0,1,2,3,4,0. `regwrite`=1 and `memtoreg`=1 in state 4 only.
- op=101011 (sw), `mem_ready` low for 2 cycles in MEMWR → states 0,1,2,5,5,5,0. `memwrite`=1 for exactly 3 cycles.
- Sequence op=000000, 001000, 000100, 000010 with `mem_ready`=1 → 4/4/3/3 cycles. In the relevant states: `aluop`=10 (RTYPEEX), `branch`=1 (BEQEX), `pcsrc`=10 (JEX).
- op=111111 with ILLEGAL_TRAP=1 → state 15 and `illegal`=1 held for 20 cycles, then reset → state 0. With ILLEGAL_TRAP=0 → state 1 then 0, and `illegal` never asserts.
- op=000101 → with `MC_BNE_EN`: state 12, `bne`=1, `branch`=0. Without it: behaves as illegal.
- `mem_ready`=0 in FETCH for 3 cycles → `irwrite`=`pcwrite`=0 throughout, then 1 for one cycle. `reset` asserted in MEMRD → state 0 next cycle.
